// File: rtl/fifo_param_if.sv
// Handshake bundle for fifo_param: producer/consumer controls and status.
// FIFO_PARAM_PEAK_EN adds the high-water mark signal to the bundle.
interface fifo_param_if #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 4
);
    localparam int CNT_W = $clog2(ENTRIES + 1);

    logic             in_read_ctrl;
    logic             in_write_ctrl;
    logic [WIDTH-1:0] in_write_data;
    logic             in_clear_err;
    logic [WIDTH-1:0] out_read_data;
    logic             out_is_full;
    logic             out_is_empty;
    logic             out_almost_full;
    logic             out_almost_empty;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;
    logic             out_underflow;
`ifdef FIFO_PARAM_PEAK_EN
    logic [CNT_W-1:0] out_peak_count;
`endif

    modport master (
        output in_read_ctrl, in_write_ctrl, in_write_data, in_clear_err,
        input  out_read_data, out_is_full, out_is_empty, out_almost_full,
        input  out_almost_empty, out_count, out_overflow, out_underflow
`ifdef FIFO_PARAM_PEAK_EN
        , input out_peak_count
`endif
    );

    modport slave (
        input  in_read_ctrl, in_write_ctrl, in_write_data, in_clear_err,
        output out_read_data, out_is_full, out_is_empty, out_almost_full,
        output out_almost_empty, out_count, out_overflow, out_underflow
`ifdef FIFO_PARAM_PEAK_EN
        , output out_peak_count
`endif
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous first-word-fall-through FIFO with occupancy, thresholds
// and sticky overflow/underflow flags. Optional FIFO_PARAM_PEAK_EN adds a high-water mark.
module fifo_param #(
    parameter int WIDTH    = 8,
    parameter int ENTRIES  = 4,
    parameter int AF_LEVEL = ENTRIES - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic          clk,
    input  logic          rst,
    fifo_param_if.slave   bus
);
    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = $clog2(ENTRIES + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ENTRIES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);
    localparam logic [CNT_W-1:0] AF_LV    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_LV    = CNT_W'(AE_LEVEL);
    // A threshold beyond the depth could alias after truncation, so it is masked off.
    localparam bit AF_NEVER = (AF_LEVEL > ENTRIES);

    if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
        $error("fifo_param: AE_LEVEL must be below AF_LEVEL");
    end

    logic [WIDTH-1:0] mem_q [ENTRIES];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             full, empty, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign push  = bus.in_write_ctrl & (~full | bus.in_read_ctrl);
    assign pop   = bus.in_read_ctrl & ~empty;

    always_comb begin
        wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d     = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        // Setting wins over a same-cycle clear.
        overflow_d  = (bus.in_write_ctrl & full & ~bus.in_read_ctrl)
                    | (overflow_q & ~bus.in_clear_err);
        underflow_d = (bus.in_read_ctrl & empty)
                    | (underflow_q & ~bus.in_clear_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= bus.in_write_data;
    end

    assign bus.out_read_data    = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.out_is_full      = full;
    assign bus.out_is_empty     = empty;
    assign bus.out_almost_full  = ~AF_NEVER & (count_q >= AF_LV);
    assign bus.out_almost_empty = (count_q <= AE_LV);
    assign bus.out_count        = count_q;
    assign bus.out_overflow     = overflow_q;
    assign bus.out_underflow    = underflow_q;

`ifdef FIFO_PARAM_PEAK_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (bus.in_clear_err)     peak_d = count_q;
        else if (count_d > peak_q) peak_d = count_d;
    end

    always_ff @(posedge clk) begin
        if (rst) peak_q <= '0;
        else     peak_q <= peak_d;
    end

    assign bus.out_peak_count = peak_q;
`endif
endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO and the next generation of the team's 8-bit, 4-entry FIFO.
- Generalised data width and depth; depth need not be a power of two.
- Adds first-word-fall-through read data, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Sits between byte/word producers and consumers in the datapath. Also serves as the reference DUT for the FIFO-index checker bench.

Parameters:
WIDTH, 8, data word width in bits (>=1)
ENTRIES, 4, storage depth in words (>=2, any integer)
AF_LEVEL, ENTRIES-1, out_almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 1, out_almost_empty asserted when count <= AE_LEVEL

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_read_ctrl  input  1  pop request
in_write_ctrl  input  1  push request
in_write_data  input  WIDTH  push data
in_clear_err  input  1  clears sticky error flags
out_read_data  output  WIDTH  head word (FWFT); 0 when empty
out_is_full  output  1  count == ENTRIES
out_is_empty  output  1  count == 0
out_almost_full  output  1  count >= AF_LEVEL
out_almost_empty  output  1  count <= AE_LEVEL
out_count  output  $clog2(ENTRIES+1)  current occupancy
out_overflow  output  1  sticky: push dropped while full
out_underflow  output  1  sticky: pop requested while empty

Behaviour:
- Reset (rst=1 at posedge): write_ptr=0, read_ptr=0, count=0, overflow=0, underflow=0. Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0, out_read_data=0. Storage array is not reset. Reset mid-operation discards all contents; the first post-reset cycle behaves as empty.
- Pointers: width $clog2(ENTRIES); increment modulo ENTRIES, wrapping from ENTRIES-1 to 0 explicitly (no power-of-two reliance).
- Accepted push = in_write_ctrl & (~full | in_read_ctrl). Accepted pop = in_read_ctrl & ~empty.
- Push: data written at write_ptr on the clock edge; visible at out_read_data next cycle if the FIFO was empty (write-to-read latency 1 cycle).
- Pop: read_ptr advances on the clock edge; out_read_data shows the new head in the same cycle as the updated pointer. No read latency beyond FWFT.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Flags derive combinationally from registered count; all flags update one cycle after the causing edge.
- Full with simultaneous read+write: both accepted; count stays ENTRIES, data order preserved.
- Empty with simultaneous read+write: write accepted, pop rejected, underflow set, count becomes 1.
- Write while full without read: data dropped, pointers unchanged, overflow set.
- Read while empty: no state change except underflow set.
- Sticky flags: set has priority over in_clear_err in the same cycle; otherwise in_clear_err=1 clears both next cycle.
- Threshold rules:
  - AF_LEVEL and AE_LEVEL are compared at count width.
  - AF_LEVEL > ENTRIES means almost_full only via count, so it never asserts.
  - Elaboration error if AE_LEVEL >= AF_LEVEL.

Optional Feature:
FIFO_PARAM_PEAK_EN
- Defined: adds output out_peak_count (width $clog2(ENTRIES+1)), a registered high-water mark.
  - Updates to max(peak, next count) each cycle.
  - Cleared to 0 by rst; set to the current count by in_clear_err.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, almost_empty=1, count=0, out_read_data=0, errors=0.
- ENTRIES=4, push 0xA1,0xB2,0xC3,0xD4 on consecutive cycles -> count 1,2,3,4; almost_full at count 3; full at 4; pop x4 returns A1,B2,C3,D4 in order, each word valid in the cycle before its pop edge.
- ENTRIES=5 (non power of two), 12 push/pop pairs interleaved -> pointers wrap 4->0, data order intact, no error flags.
- Full, then simultaneous read+write of 0x55 -> count stays 4, head advances, 0x55 popped last; full then push-only 0x66 -> 0x66 dropped, overflow=1 until in_clear_err pulse clears it next cycle.
- Empty, simultaneous read+write 0x77 -> count=1, out_read_data=0x77 next cycle, underflow=1.
- Mid-operation rst with count=3 -> next cycle count=0, empty=1, out_read_data=0. With FIFO_PARAM_PEAK_EN: peak=3 before reset, 0 after.
